// File: rtl/rcu_wb_collector_pkg.sv
// Shared RCU constants plus the writeback FIFO entry type.
//   XLEN, ROB_INDEX_WIDTH, PHY_REG_ADDR_WIDTH, PC_WIDTH : core widths
//   wb_entry_t : {rob_index, prd_addr, data} payload held in the writeback FIFO
//   rob_age()  : distance of a ROB index from the current ROB head
package rcu_wb_collector_pkg;

  localparam int unsigned XLEN               = 64;
  localparam int unsigned ROB_INDEX_WIDTH    = 6;
  localparam int unsigned PHY_REG_ADDR_WIDTH = 6;
  localparam int unsigned PC_WIDTH           = 32;

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0]    rob_index;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr;
    logic [XLEN-1:0]               data;
  } wb_entry_t;

  // Modular distance from the head; a smaller value means an older instruction.
  function automatic logic [ROB_INDEX_WIDTH-1:0] rob_age(
    input logic [ROB_INDEX_WIDTH-1:0] idx,
    input logic [ROB_INDEX_WIDTH-1:0] head
  );
    return idx - head;
  endfunction

endpackage

// File: rtl/rcu_wb_collector_if.sv
// Bundle of FU writeback completions, ROB head / flush, and the collector's
// write-port, stall, redirect and error outputs.
//   slave  : the collector (consumes completions, drives write ports)
//   master : the environment (drives completions, observes write ports)
interface rcu_wb_collector_if;
  import rcu_wb_collector_pkg::*;

  logic                          fu_rcu_alu1_resp_valid_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_alu1_wrb_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_alu1_wrb_prd_addr_i;
  logic [XLEN-1:0]               fu_rcu_alu1_wrb_data_i;
  logic                          fu_rcu_alu1_branch_predict_miss_i;
  logic [PC_WIDTH-1:0]           fu_rcu_alu1_final_next_pc_i;

  logic                          fu_rcu_alu2_resp_valid_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_alu2_wrb_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_alu2_wrb_prd_addr_i;
  logic [XLEN-1:0]               fu_rcu_alu2_wrb_data_i;
  logic                          fu_rcu_alu2_branch_predict_miss_i;
  logic [PC_WIDTH-1:0]           fu_rcu_alu2_final_next_pc_i;

  logic                          fu_rcu_lsu_comm_vld_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_lsu_comm_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_lsu_comm_rd_addr_i;
  logic [XLEN-1:0]               fu_rcu_lsu_comm_data_i;

  logic [ROB_INDEX_WIDTH-1:0]    rob_head_i;
  logic                          flush_i;

  logic                          wb0_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb0_rob_index_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb0_prd_addr_o;
  logic [XLEN-1:0]               wb0_data_o;
  logic                          wb1_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb1_rob_index_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb1_prd_addr_o;
  logic [XLEN-1:0]               wb1_data_o;

  logic                          wb_issue_stall_o;
  logic                          redirect_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    redirect_rob_index_o;
  logic [PC_WIDTH-1:0]           redirect_pc_o;
  logic                          overflow_err_o;

  modport slave (
    input  fu_rcu_alu1_resp_valid_i, fu_rcu_alu1_wrb_rob_index_i, fu_rcu_alu1_wrb_prd_addr_i,
           fu_rcu_alu1_wrb_data_i, fu_rcu_alu1_branch_predict_miss_i, fu_rcu_alu1_final_next_pc_i,
           fu_rcu_alu2_resp_valid_i, fu_rcu_alu2_wrb_rob_index_i, fu_rcu_alu2_wrb_prd_addr_i,
           fu_rcu_alu2_wrb_data_i, fu_rcu_alu2_branch_predict_miss_i, fu_rcu_alu2_final_next_pc_i,
           fu_rcu_lsu_comm_vld_i, fu_rcu_lsu_comm_rob_index_i, fu_rcu_lsu_comm_rd_addr_i,
           fu_rcu_lsu_comm_data_i, rob_head_i, flush_i,
    output wb0_vld_o, wb0_rob_index_o, wb0_prd_addr_o, wb0_data_o,
           wb1_vld_o, wb1_rob_index_o, wb1_prd_addr_o, wb1_data_o,
           wb_issue_stall_o, redirect_vld_o, redirect_rob_index_o, redirect_pc_o, overflow_err_o
  );

  modport master (
    output fu_rcu_alu1_resp_valid_i, fu_rcu_alu1_wrb_rob_index_i, fu_rcu_alu1_wrb_prd_addr_i,
           fu_rcu_alu1_wrb_data_i, fu_rcu_alu1_branch_predict_miss_i, fu_rcu_alu1_final_next_pc_i,
           fu_rcu_alu2_resp_valid_i, fu_rcu_alu2_wrb_rob_index_i, fu_rcu_alu2_wrb_prd_addr_i,
           fu_rcu_alu2_wrb_data_i, fu_rcu_alu2_branch_predict_miss_i, fu_rcu_alu2_final_next_pc_i,
           fu_rcu_lsu_comm_vld_i, fu_rcu_lsu_comm_rob_index_i, fu_rcu_lsu_comm_rd_addr_i,
           fu_rcu_lsu_comm_data_i, rob_head_i, flush_i,
    input  wb0_vld_o, wb0_rob_index_o, wb0_prd_addr_o, wb0_data_o,
           wb1_vld_o, wb1_rob_index_o, wb1_prd_addr_o, wb1_data_o,
           wb_issue_stall_o, redirect_vld_o, redirect_rob_index_o, redirect_pc_o, overflow_err_o
  );

endinterface

// File: rtl/rcu_wb_fifo.sv
// Circular buffer with up to three pushes and two pops per cycle.
//   clk, rstn  : clock, asynchronous active-low reset
//   flush      : synchronous clear of head, tail and count
//   push_cnt   : number of entries of push_data written at the tail (0..3)
//   push_data  : compacted entries, slot 0 goes first
//   pop_cnt    : number of head entries retired (0..2, never more than count)
//   head_data  : the two oldest entries (contents undefined beyond count)
//   count      : occupancy, one bit wider than the pointers so full != empty
module rcu_wb_fifo
  import rcu_wb_collector_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DEPTH_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [1:0]           push_cnt,
  input  wb_entry_t [2:0]      push_data,
  input  logic [1:0]           pop_cnt,
  output wb_entry_t [1:0]      head_data,
  output logic [DEPTH_WIDTH:0] count
);

  localparam int unsigned CW = DEPTH_WIDTH + 1;

  wb_entry_t              mem [DEPTH];
  logic [DEPTH_WIDTH-1:0] head;
  logic [DEPTH_WIDTH-1:0] tail;

  // Storage needs no reset: nothing is observable past count.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 3; k++) begin
      if (!flush && k < 32'(push_cnt)) begin
        mem[tail + DEPTH_WIDTH'(k)] <= push_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + DEPTH_WIDTH'(pop_cnt);
      tail  <= tail + DEPTH_WIDTH'(push_cnt);
      count <= count - CW'(pop_cnt) + CW'(push_cnt);
    end
  end

  assign head_data[0] = mem[head];
  assign head_data[1] = mem[head + DEPTH_WIDTH'(1)];

endmodule

// File: rtl/rcu_wb_collector.sv
// RCU writeback collector: compacts ALU1/ALU2/LSU completions into an ordered
// FIFO, drains up to two per cycle onto the PRF/ROB write ports, stalls issue
// when free space runs low, and keeps the oldest pending branch mispredict.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : completions, ROB head, flush in; write ports, stall,
//               redirect and sticky overflow error out
module rcu_wb_collector
  import rcu_wb_collector_pkg::*;
#(
  parameter int unsigned WB_FIFO_DEPTH       = 16,
  parameter int unsigned WB_FIFO_DEPTH_WIDTH = 4,
  parameter int unsigned STALL_MARGIN        = 6
) (
  input logic               clk,
  input logic               rstn,
  rcu_wb_collector_if.slave bus
);

  localparam int unsigned CW = WB_FIFO_DEPTH_WIDTH + 1;
  localparam int unsigned FW = WB_FIFO_DEPTH_WIDTH + 2;

  wb_entry_t [2:0] src;
  logic [2:0]      src_vld;
  wb_entry_t [2:0] cmp;
  wb_entry_t [1:0] head_data;
  logic [CW-1:0]   count;
  logic [FW-1:0]   free;
  logic [1:0]      n_vld;
  logic [1:0]      slot;
  logic [1:0]      push_cnt;
  logic [1:0]      pop_cnt;
  logic            drop;

  logic                       rd_vld, best_vld;
  logic [ROB_INDEX_WIDTH-1:0] rd_rob, best_rob;
  logic [PC_WIDTH-1:0]        rd_pc, best_pc;
  logic                       ovf;

  assign src_vld = {bus.fu_rcu_lsu_comm_vld_i, bus.fu_rcu_alu2_resp_valid_i,
                    bus.fu_rcu_alu1_resp_valid_i};
  assign src[0]  = '{rob_index: bus.fu_rcu_alu1_wrb_rob_index_i,
                     prd_addr:  bus.fu_rcu_alu1_wrb_prd_addr_i,
                     data:      bus.fu_rcu_alu1_wrb_data_i};
  assign src[1]  = '{rob_index: bus.fu_rcu_alu2_wrb_rob_index_i,
                     prd_addr:  bus.fu_rcu_alu2_wrb_prd_addr_i,
                     data:      bus.fu_rcu_alu2_wrb_data_i};
  assign src[2]  = '{rob_index: bus.fu_rcu_lsu_comm_rob_index_i,
                     prd_addr:  bus.fu_rcu_lsu_comm_rd_addr_i,
                     data:      bus.fu_rcu_lsu_comm_data_i};

  // Pack valid sources into consecutive slots in ALU1, ALU2, LSU order.
  always_comb begin
    cmp  = '0;
    slot = 2'd0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (src_vld[i]) begin
        cmp[slot] = src[i];
        slot      = slot + 2'd1;
      end
    end
  end

  always_comb begin
    if (count >= CW'(2))      pop_cnt = 2'd2;
    else if (count != '0)     pop_cnt = 2'd1;
    else                      pop_cnt = 2'd0;
  end

  assign n_vld = {1'b0, src_vld[0]} + {1'b0, src_vld[1]} + {1'b0, src_vld[2]};
  assign free  = FW'(WB_FIFO_DEPTH) - FW'(count) + FW'(pop_cnt);

  // Truncating the compacted list keeps the earliest slots, so LSU is lost
  // first and then ALU2. Completions during a flush are discarded, not dropped.
  always_comb begin
    push_cnt = n_vld;
    drop     = 1'b0;
    if (bus.flush_i) begin
      push_cnt = 2'd0;
    end else if (FW'(n_vld) > free) begin
      push_cnt = free[1:0];
      drop     = 1'b1;
    end
  end

  rcu_wb_fifo #(
    .DEPTH       (WB_FIFO_DEPTH),
    .DEPTH_WIDTH (WB_FIFO_DEPTH_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (bus.flush_i),
    .push_cnt  (push_cnt),
    .push_data (cmp),
    .pop_cnt   (pop_cnt),
    .head_data (head_data),
    .count     (count)
  );

  // Payloads are forced to zero when the port is idle.
  assign bus.wb0_vld_o       = (pop_cnt != 2'd0);
  assign bus.wb1_vld_o       = (pop_cnt == 2'd2);
  assign bus.wb0_rob_index_o = bus.wb0_vld_o ? head_data[0].rob_index : '0;
  assign bus.wb0_prd_addr_o  = bus.wb0_vld_o ? head_data[0].prd_addr  : '0;
  assign bus.wb0_data_o      = bus.wb0_vld_o ? head_data[0].data      : '0;
  assign bus.wb1_rob_index_o = bus.wb1_vld_o ? head_data[1].rob_index : '0;
  assign bus.wb1_prd_addr_o  = bus.wb1_vld_o ? head_data[1].prd_addr  : '0;
  assign bus.wb1_data_o      = bus.wb1_vld_o ? head_data[1].data      : '0;

  assign bus.wb_issue_stall_o = (CW'(WB_FIFO_DEPTH) - count) < CW'(STALL_MARGIN);

  // Oldest of pending redirect and this cycle's ALU mispredicts, ages taken
  // against the current ROB head.
  always_comb begin
    best_vld = rd_vld;
    best_rob = rd_rob;
    best_pc  = rd_pc;
    if (bus.fu_rcu_alu1_resp_valid_i && bus.fu_rcu_alu1_branch_predict_miss_i &&
        (!best_vld || rob_age(bus.fu_rcu_alu1_wrb_rob_index_i, bus.rob_head_i) <
                      rob_age(best_rob, bus.rob_head_i))) begin
      best_vld = 1'b1;
      best_rob = bus.fu_rcu_alu1_wrb_rob_index_i;
      best_pc  = bus.fu_rcu_alu1_final_next_pc_i;
    end
    if (bus.fu_rcu_alu2_resp_valid_i && bus.fu_rcu_alu2_branch_predict_miss_i &&
        (!best_vld || rob_age(bus.fu_rcu_alu2_wrb_rob_index_i, bus.rob_head_i) <
                      rob_age(best_rob, bus.rob_head_i))) begin
      best_vld = 1'b1;
      best_rob = bus.fu_rcu_alu2_wrb_rob_index_i;
      best_pc  = bus.fu_rcu_alu2_final_next_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld <= 1'b0;
      rd_rob <= '0;
      rd_pc  <= '0;
    end else if (bus.flush_i) begin
      rd_vld <= 1'b0;
      rd_rob <= '0;
      rd_pc  <= '0;
    end else begin
      rd_vld <= best_vld;
      rd_rob <= best_rob;
      rd_pc  <= best_pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
  end

  assign bus.redirect_vld_o       = rd_vld;
  assign bus.redirect_rob_index_o = rd_rob;
  assign bus.redirect_pc_o        = rd_pc;
  assign bus.overflow_err_o       = ovf;

endmodule

// File: tb/tb_rcu_wb_collector.sv
// Randomized plus directed bench for rcu_wb_collector against a queue-based
// reference model of the writeback FIFO, redirect and overflow behaviour.
module tb_rcu_wb_collector;
  import rcu_wb_collector_pkg::*;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 6;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rcu_wb_collector_if bus();

  rcu_wb_collector #(
    .WB_FIFO_DEPTH       (DEPTH),
    .WB_FIFO_DEPTH_WIDTH (4),
    .STALL_MARGIN        (MARGIN)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  wb_entry_t    q[$];
  logic         m_rd_vld;
  logic [5:0]   m_rd_rob;
  logic [31:0]  m_rd_pc;
  logic         m_ovf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.fu_rcu_alu1_resp_valid_i = 0; bus.fu_rcu_alu1_wrb_rob_index_i = 0;
    bus.fu_rcu_alu1_wrb_prd_addr_i = 0; bus.fu_rcu_alu1_wrb_data_i = 0;
    bus.fu_rcu_alu1_branch_predict_miss_i = 0; bus.fu_rcu_alu1_final_next_pc_i = 0;
    bus.fu_rcu_alu2_resp_valid_i = 0; bus.fu_rcu_alu2_wrb_rob_index_i = 0;
    bus.fu_rcu_alu2_wrb_prd_addr_i = 0; bus.fu_rcu_alu2_wrb_data_i = 0;
    bus.fu_rcu_alu2_branch_predict_miss_i = 0; bus.fu_rcu_alu2_final_next_pc_i = 0;
    bus.fu_rcu_lsu_comm_vld_i = 0; bus.fu_rcu_lsu_comm_rob_index_i = 0;
    bus.fu_rcu_lsu_comm_rd_addr_i = 0; bus.fu_rcu_lsu_comm_data_i = 0;
    bus.flush_i = 0;
  endtask

  task automatic set_alu1(input logic v, input logic [5:0] rob, input logic [5:0] prd,
                          input logic [63:0] d, input logic miss, input logic [31:0] pc);
    bus.fu_rcu_alu1_resp_valid_i = v; bus.fu_rcu_alu1_wrb_rob_index_i = rob;
    bus.fu_rcu_alu1_wrb_prd_addr_i = prd; bus.fu_rcu_alu1_wrb_data_i = d;
    bus.fu_rcu_alu1_branch_predict_miss_i = miss; bus.fu_rcu_alu1_final_next_pc_i = pc;
  endtask

  task automatic set_alu2(input logic v, input logic [5:0] rob, input logic [5:0] prd,
                          input logic [63:0] d, input logic miss, input logic [31:0] pc);
    bus.fu_rcu_alu2_resp_valid_i = v; bus.fu_rcu_alu2_wrb_rob_index_i = rob;
    bus.fu_rcu_alu2_wrb_prd_addr_i = prd; bus.fu_rcu_alu2_wrb_data_i = d;
    bus.fu_rcu_alu2_branch_predict_miss_i = miss; bus.fu_rcu_alu2_final_next_pc_i = pc;
  endtask

  task automatic set_lsu(input logic v, input logic [5:0] rob, input logic [5:0] prd,
                         input logic [63:0] d);
    bus.fu_rcu_lsu_comm_vld_i = v; bus.fu_rcu_lsu_comm_rob_index_i = rob;
    bus.fu_rcu_lsu_comm_rd_addr_i = prd; bus.fu_rcu_lsu_comm_data_i = d;
  endtask

  function automatic int age_of(input logic [5:0] rob, input logic [5:0] head);
    return (int'(rob) - int'(head) + 64) % 64;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rd_vld = 0; m_rd_rob = 0; m_rd_pc = 0; m_ovf = 0;
  endtask

  // One clock of the reference behaviour, using the inputs currently driven.
  task automatic model_step();
    int pops, room, best, best_age, a;
    wb_entry_t  inc[$];
    logic [5:0] c_rob[$];
    logic [31:0] c_pc[$];
    if (bus.flush_i) begin
      q.delete();
      m_rd_vld = 0; m_rd_rob = 0; m_rd_pc = 0;
      return;
    end
    pops = (q.size() >= 2) ? 2 : q.size();
    repeat (pops) void'(q.pop_front());
    room = DEPTH - q.size();
    if (bus.fu_rcu_alu1_resp_valid_i)
      inc.push_back('{bus.fu_rcu_alu1_wrb_rob_index_i, bus.fu_rcu_alu1_wrb_prd_addr_i, bus.fu_rcu_alu1_wrb_data_i});
    if (bus.fu_rcu_alu2_resp_valid_i)
      inc.push_back('{bus.fu_rcu_alu2_wrb_rob_index_i, bus.fu_rcu_alu2_wrb_prd_addr_i, bus.fu_rcu_alu2_wrb_data_i});
    if (bus.fu_rcu_lsu_comm_vld_i)
      inc.push_back('{bus.fu_rcu_lsu_comm_rob_index_i, bus.fu_rcu_lsu_comm_rd_addr_i, bus.fu_rcu_lsu_comm_data_i});
    foreach (inc[i]) begin
      if (room > 0) begin q.push_back(inc[i]); room--; end
      else m_ovf = 1;
    end
    if (m_rd_vld) begin c_rob.push_back(m_rd_rob); c_pc.push_back(m_rd_pc); end
    if (bus.fu_rcu_alu1_resp_valid_i && bus.fu_rcu_alu1_branch_predict_miss_i) begin
      c_rob.push_back(bus.fu_rcu_alu1_wrb_rob_index_i); c_pc.push_back(bus.fu_rcu_alu1_final_next_pc_i);
    end
    if (bus.fu_rcu_alu2_resp_valid_i && bus.fu_rcu_alu2_branch_predict_miss_i) begin
      c_rob.push_back(bus.fu_rcu_alu2_wrb_rob_index_i); c_pc.push_back(bus.fu_rcu_alu2_final_next_pc_i);
    end
    best = -1; best_age = 0;
    foreach (c_rob[i]) begin
      a = age_of(c_rob[i], bus.rob_head_i);
      if (best < 0 || a < best_age) begin best = i; best_age = a; end
    end
    if (best >= 0) begin
      m_rd_vld = 1; m_rd_rob = c_rob[best]; m_rd_pc = c_pc[best];
    end
  endtask

  task automatic check_outputs();
    wb_entry_t e0, e1;
    e0 = (q.size() >= 1) ? q[0] : '0;
    e1 = (q.size() >= 2) ? q[1] : '0;
    check_val("wb0_vld", bus.wb0_vld_o, q.size() >= 1);
    check_val("wb0_rob", bus.wb0_rob_index_o, e0.rob_index);
    check_val("wb0_prd", bus.wb0_prd_addr_o, e0.prd_addr);
    check_val("wb0_data", bus.wb0_data_o, e0.data);
    check_val("wb1_vld", bus.wb1_vld_o, q.size() >= 2);
    check_val("wb1_rob", bus.wb1_rob_index_o, e1.rob_index);
    check_val("wb1_prd", bus.wb1_prd_addr_o, e1.prd_addr);
    check_val("wb1_data", bus.wb1_data_o, e1.data);
    check_val("stall", bus.wb_issue_stall_o, (DEPTH - q.size()) < MARGIN);
    check_val("rd_vld", bus.redirect_vld_o, m_rd_vld);
    check_val("rd_rob", bus.redirect_rob_index_o, m_rd_rob);
    check_val("rd_pc", bus.redirect_pc_o, m_rd_pc);
    check_val("ovf", bus.overflow_err_o, m_ovf);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_wb0_vld"}, bus.wb0_vld_o, 0);
    check_val({pfx, "_wb0_data"}, bus.wb0_data_o, 0);
    check_val({pfx, "_wb1_vld"}, bus.wb1_vld_o, 0);
    check_val({pfx, "_stall"}, bus.wb_issue_stall_o, 0);
    check_val({pfx, "_rd_vld"}, bus.redirect_vld_o, 0);
    check_val({pfx, "_rd_rob"}, bus.redirect_rob_index_o, 0);
    check_val({pfx, "_ovf"}, bus.overflow_err_o, 0);
  endtask

  initial begin
    logic [5:0] r1, r2;
    int thr;
    rstn = 0;
    clear_inputs();
    bus.rob_head_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1;

    // Single ALU1 completion
    set_alu1(1, 6'd5, 6'd12, 64'hA5, 0, 0);
    #1;
    check_val("t1_no_bypass", bus.wb0_vld_o, 0);
    step();
    check_val("t1_wb0_vld", bus.wb0_vld_o, 1);
    check_val("t1_wb0_rob", bus.wb0_rob_index_o, 5);
    check_val("t1_wb0_prd", bus.wb0_prd_addr_o, 12);
    check_val("t1_wb0_data", bus.wb0_data_o, 64'hA5);
    check_val("t1_wb1_vld", bus.wb1_vld_o, 0);
    clear_inputs();
    step();
    check_val("t1_empty", bus.wb0_vld_o, 0);

    // Three completions in one cycle keep ALU1, ALU2, LSU order
    set_alu1(1, 6'd1, 6'd21, 64'h11, 0, 0);
    set_alu2(1, 6'd2, 6'd22, 64'h22, 0, 0);
    set_lsu (1, 6'd3, 6'd23, 64'h33);
    step();
    check_val("t2_wb0_rob", bus.wb0_rob_index_o, 1);
    check_val("t2_wb1_rob", bus.wb1_rob_index_o, 2);
    clear_inputs();
    step();
    check_val("t2_c2_wb0_rob", bus.wb0_rob_index_o, 3);
    check_val("t2_c2_wb1_vld", bus.wb1_vld_o, 0);
    step();

    // Redirect age selection around ROB wrap
    bus.rob_head_i = 6'd60;
    set_alu1(1, 6'd2, 6'd1, 64'h1, 1, 32'h1000);
    set_alu2(1, 6'd62, 6'd2, 64'h2, 1, 32'h2000);
    step();
    check_val("t3_rob62", bus.redirect_rob_index_o, 62);
    check_val("t3_pc62", bus.redirect_pc_o, 32'h2000);
    clear_inputs();
    set_alu1(1, 6'd61, 6'd3, 64'h3, 1, 32'h3000);
    step();
    check_val("t3_rob61", bus.redirect_rob_index_o, 61);
    set_alu1(1, 6'd3, 6'd4, 64'h4, 1, 32'h4000);
    step();
    check_val("t3_keep61", bus.redirect_rob_index_o, 61);
    check_val("t3_keep_pc", bus.redirect_pc_o, 32'h3000);

    // Flush with four entries held and a redirect pending
    clear_inputs();
    repeat (4) step();
    set_alu1(1, 6'd10, 6'd10, 64'h10, 0, 0);
    set_alu2(1, 6'd11, 6'd11, 64'h11, 0, 0);
    set_lsu (1, 6'd12, 6'd12, 64'h12);
    step();
    set_alu1(1, 6'd13, 6'd13, 64'h13, 0, 0);
    set_alu2(1, 6'd14, 6'd14, 64'h14, 0, 0);
    set_lsu (1, 6'd15, 6'd15, 64'h15);
    step();
    clear_inputs();
    set_alu1(1, 6'd20, 6'd20, 64'h20, 0, 0);
    bus.flush_i = 1;
    step();
    check_val("t4_wb0_vld", bus.wb0_vld_o, 0);
    check_val("t4_rd_vld", bus.redirect_vld_o, 0);
    check_val("t4_stall", bus.wb_issue_stall_o, 0);
    clear_inputs();
    step();
    check_val("t4_alu1_gone", bus.wb0_vld_o, 0);

    // Three pushes every cycle until the FIFO saturates and drops
    for (int i = 0; i < 20; i++) begin
      set_alu1(1, 6'(3 * i),     6'(i),     64'(1000 + 3 * i), 0, 0);
      set_alu2(1, 6'(3 * i + 1), 6'(i + 1), 64'(1001 + 3 * i), 0, 0);
      set_lsu (1, 6'(3 * i + 2), 6'(i + 2), 64'(1002 + 3 * i));
      step();
      if (i == 0) check_val("t5_stall_low", bus.wb_issue_stall_o, 0);
    end
    check_val("t5_stall_high", bus.wb_issue_stall_o, 1);
    check_val("t5_ovf", bus.overflow_err_o, 1);
    clear_inputs();
    repeat (9) step();

    // Asynchronous reset while the FIFO is non-empty
    set_alu1(1, 6'd40, 6'd40, 64'h40, 1, 32'h40);
    set_alu2(1, 6'd41, 6'd41, 64'h41, 0, 0);
    set_lsu (1, 6'd42, 6'd42, 64'h42);
    step();
    clear_inputs();
    #2;
    rstn = 0;
    #1;
    check_all_zero("arst");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1;
    check_outputs();

    // Randomized traffic with bursty load, mispredicts and occasional flush
    for (int i = 0; i < 800; i++) begin
      thr = (((i / 40) % 2) == 0) ? 90 : 30;
      clear_inputs();
      if ($urandom_range(9) == 0) bus.rob_head_i = 6'($urandom);
      set_alu1($urandom_range(99) < thr, 6'($urandom), 6'($urandom), {$urandom, $urandom},
               $urandom_range(6) == 0, $urandom);
      set_alu2($urandom_range(99) < thr, 6'($urandom), 6'($urandom), {$urandom, $urandom},
               $urandom_range(6) == 0, $urandom);
      set_lsu ($urandom_range(99) < thr, 6'($urandom), 6'($urandom), {$urandom, $urandom});
      r1 = bus.fu_rcu_alu1_wrb_rob_index_i;
      r2 = bus.fu_rcu_alu2_wrb_rob_index_i;
      // Keep candidate ages distinct, as real ROB indices are.
      if (m_rd_vld && r1 == m_rd_rob) bus.fu_rcu_alu1_branch_predict_miss_i = 0;
      if ((m_rd_vld && r2 == m_rd_rob) || r2 == r1) bus.fu_rcu_alu2_branch_predict_miss_i = 0;
      bus.flush_i = ($urandom_range(59) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
